// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and the opcode length decoder.
package instr_fetch_pkg;

  localparam int unsigned PROG_MEM_SIZE_DEF  = 16;
  localparam int unsigned PROG_MEM_WIDTH_DEF = 8;
  localparam int unsigned OP_W               = 8;
  localparam int unsigned IMM_W              = 16;
  localparam int unsigned LEN_W              = 2;
  localparam int unsigned STAT_W             = 32;

  // Opcodes whose low five bits all set carry immediates; bit 7 selects the 2-byte form.
  localparam logic [4:0]  IMM_GRP_MATCH = 5'b11111;
  localparam int unsigned IMM_LONG_BIT  = 7;

  typedef enum logic [2:0] {
    S_PRIME = 3'd0,
    S_OP    = 3'd1,
    S_IMM0  = 3'd2,
    S_IMM1  = 3'd3,
    S_HOLD  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic [LEN_W-1:0] len;
  } instr_t;

endpackage

// File: rtl/instr_fetch_len_dec.sv
// Combinational opcode -> immediate byte count (0, 1 or 2); shared with the decoder.
module instr_fetch_len_dec
  import instr_fetch_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [LEN_W-1:0] len_c
);

  always_comb begin
    len_c = '0;
    if (op[4:0] == IMM_GRP_MATCH) begin
      len_c = op[IMM_LONG_BIT] ? LEN_W'(2) : LEN_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads program memory a byte per cycle, assembles op + immediates, hands them
// to the decoder over valid/ready. Define IFETCH_STATS_EN to add accept/stall counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PROG_MEM_SIZE  = PROG_MEM_SIZE_DEF,
  parameter int unsigned PROG_MEM_WIDTH = PROG_MEM_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PROG_MEM_WIDTH-1:0] prog_mem_out,
  output logic [PROG_MEM_SIZE-1:0]  prog_mem_addr,
  input  logic                      redirect_valid,
  input  logic [PROG_MEM_SIZE-1:0]  redirect_addr,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [OP_W-1:0]           instr_op,
  output logic [IMM_W-1:0]          instr_imm,
  output logic [LEN_W-1:0]          instr_len,
  output logic [PROG_MEM_SIZE-1:0]  instr_pc
`ifdef IFETCH_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_instr_count,
  output logic [STAT_W-1:0]         stat_stall_count
`endif
);

  fetch_state_e             state_q, state_d;
  logic [PROG_MEM_SIZE-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [PROG_MEM_SIZE-1:0] pc_q, pc_d;
  instr_t                   instr_q, instr_d;
  logic                     valid_q, valid_d;
  logic [LEN_W-1:0]         byte_len_c;
  logic [OP_W-1:0]          mem_byte_c;

  assign mem_byte_c = OP_W'(prog_mem_out);

  instr_fetch_len_dec u_len_dec (
    .op    (mem_byte_c),
    .len_c (byte_len_c)
  );

  // Next-state: the returning byte always belongs to the request issued the cycle before.
  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;

    case (state_q)
      S_PRIME: begin
        fetch_ptr_d = fetch_ptr_q + PROG_MEM_SIZE'(1);
        state_d     = S_OP;
      end
      S_OP: begin
        instr_d.op  = mem_byte_c;
        instr_d.imm = '0;
        instr_d.len = byte_len_c;
        pc_d        = fetch_ptr_q - PROG_MEM_SIZE'(1);
        if (byte_len_c != '0) begin
          fetch_ptr_d = fetch_ptr_q + PROG_MEM_SIZE'(1);
          state_d     = S_IMM0;
        end else begin
          state_d = S_HOLD;
          valid_d = 1'b1;
        end
      end
      S_IMM0: begin
        instr_d.imm[7:0] = mem_byte_c;
        if (instr_q.len == LEN_W'(2)) begin
          fetch_ptr_d = fetch_ptr_q + PROG_MEM_SIZE'(1);
          state_d     = S_IMM1;
        end else begin
          state_d = S_HOLD;
          valid_d = 1'b1;
        end
      end
      S_IMM1: begin
        instr_d.imm[15:8] = mem_byte_c;
        state_d           = S_HOLD;
        valid_d           = 1'b1;
      end
      S_HOLD: begin
        if (instr_ready) begin
          fetch_ptr_d = fetch_ptr_q + PROG_MEM_SIZE'(1);
          state_d     = S_OP;
          valid_d     = 1'b0;
        end
      end
      default: begin
        state_d = S_PRIME;
        valid_d = 1'b0;
      end
    endcase

    // Redirect wins over everything; the byte in flight is dropped by restarting in PRIME.
    if (redirect_valid) begin
      fetch_ptr_d = redirect_addr;
      state_d     = S_PRIME;
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PRIME;
      fetch_ptr_q <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  assign prog_mem_addr = fetch_ptr_q;
  assign instr_valid   = valid_q;
  assign instr_op      = instr_q.op;
  assign instr_imm     = instr_q.imm;
  assign instr_len     = instr_q.len;
  assign instr_pc      = pc_q;

`ifdef IFETCH_STATS_EN
  logic [STAT_W-1:0] stat_instr_count_q, stat_instr_count_d;
  logic [STAT_W-1:0] stat_stall_count_q, stat_stall_count_d;

  // Free-running, wrapping handshake counters; redirect does not touch them.
  always_comb begin
    stat_instr_count_d = stat_instr_count_q;
    stat_stall_count_d = stat_stall_count_q;
    if (valid_q) begin
      if (instr_ready) begin
        stat_instr_count_d = stat_instr_count_q + STAT_W'(1);
      end else begin
        stat_stall_count_d = stat_stall_count_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_instr_count_q <= '0;
      stat_stall_count_q <= '0;
    end else begin
      stat_instr_count_q <= stat_instr_count_d;
      stat_stall_count_q <= stat_stall_count_d;
    end
  end

  assign stat_instr_count = stat_instr_count_q;
  assign stat_stall_count = stat_stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked against an
// instruction-level model of program memory (decodes straight from mem[] at the model pc).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  prog_mem_out;
  logic [15:0] prog_mem_addr;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic [15:0] instr_imm;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_instr_count;
  logic [31:0] stat_stall_count;
  int unsigned m_icnt, m_scnt;
`endif

  logic [7:0] mem [0:65535];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Synchronous-read program memory
  always @(posedge clk) prog_mem_out <= mem[prog_mem_addr];

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .prog_mem_out   (prog_mem_out),
    .prog_mem_addr  (prog_mem_addr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_imm      (instr_imm),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc)
`ifdef IFETCH_STATS_EN
    ,
    .stat_instr_count (stat_instr_count),
    .stat_stall_count (stat_stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_len(input logic [7:0] op);
    if (op[4:0] != 5'h1f) return 0;
    return op[7] ? 2 : 1;
  endfunction

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [15:0] imm,
                           input int unsigned len, input logic [15:0] pc);
    chk({tag, "_valid"}, instr_valid, 1'b1);
    chk({tag, "_op"}, instr_op, op);
    chk({tag, "_imm"}, instr_imm, imm);
    chk({tag, "_len"}, instr_len, len);
    chk({tag, "_pc"}, instr_pc, pc);
  endtask

  task automatic wait_valid(input string tag, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!instr_valid && cyc < max);
    if (!instr_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Ends on the negedge where reset is released (fetch sits in its priming cycle).
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [15:0] m_pc, raddr;
    int unsigned m_wait, e_len;
    logic [7:0]  e_op;
    logic [15:0] e_imm;
    logic        exp_v, ready_n, redir_n, accept;

    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Async reset in the middle of an instruction, then long-immediate fetch
    mem[0] = 8'h9F; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h02;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_addr", prog_mem_addr, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_op", instr_op, 8'h00);
    chk("rst_imm", instr_imm, 16'h0000);
    chk("rst_len", instr_len, 2'd0);
    chk("rst_pc", instr_pc, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    wait_valid("long", 20, cyc);
    chk("long_lat", cyc, 4);
    chk_instr("long", 8'h9F, 16'h1234, 2, 16'h0000);
    wait_valid("after_long", 20, cyc);
    chk("after_long_lat", cyc, 2);
    chk_instr("after_long", 8'h02, 16'h0000, 0, 16'h0003);

    // Back-to-back zero-immediate instructions: one every two cycles
    mem[0] = 8'h02; mem[1] = 8'h04; mem[2] = 8'h06;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_valid("short", 20, cyc);
      chk("short_lat", cyc, 2);
      chk_instr("short", 8'(2 + 2 * i), 16'h0000, 0, 16'(i));
    end

    // Short immediate held through a 5-cycle stall
    mem[0] = 8'h1F; mem[1] = 8'hAB;
    instr_ready = 1'b0;
    do_reset();
    wait_valid("stall", 20, cyc);
    chk("stall_lat", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      chk_instr("stall_hold", 8'h1F, 16'h00AB, 1, 16'h0000);
      chk("stall_addr", prog_mem_addr, 16'h0002);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("stall_released", instr_valid, 1'b0);
    chk("stall_next_addr", prog_mem_addr, 16'h0003);

    // Redirect while the first immediate byte is in flight
    mem[0] = 8'h9F; mem[1] = 8'h11; mem[2] = 8'h22; mem[16'h0100] = 8'h05;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_novalid", instr_valid, 1'b0);
    wait_valid("redir", 20, cyc);
    chk("redir_lat", cyc, 2);
    chk_instr("redir", 8'h05, 16'h0000, 0, 16'h0100);

    // Redirect coinciding with an accepted handshake; target straddles the address wrap
    mem[16'hFFFF] = 8'h9F; mem[0] = 8'hCD; mem[1] = 8'hAB; mem[2] = 8'h04;
    redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid("wrap", 20, cyc);
    chk("wrap_lat", cyc, 4);
    chk_instr("wrap", 8'h9F, 16'hABCD, 2, 16'hFFFF);
    wait_valid("wrap_next", 20, cyc);
    chk_instr("wrap_next", 8'h04, 16'h0000, 0, 16'h0002);

    // Randomized run against the memory-level model
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      if ($urandom_range(2) == 0) mem[i][4:0] = 5'h1f;
    end
    do_reset();
    m_pc = 16'h0000;
    m_wait = 1 + ref_len(mem[0]);
`ifdef IFETCH_STATS_EN
    m_icnt = 0; m_scnt = 0;
`endif
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 2000) begin
        #2 reset = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("rnd_rst_addr", prog_mem_addr, 16'h0000);
        chk("rnd_rst_valid", instr_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_pc = 16'h0000;
        m_wait = 1 + ref_len(mem[0]);
`ifdef IFETCH_STATS_EN
        m_icnt = 0; m_scnt = 0;
`endif
        continue;
      end
      exp_v = (m_wait == 0);
      chk("rnd_valid", instr_valid, exp_v);
`ifdef IFETCH_STATS_EN
      chk("rnd_stat_instr", stat_instr_count, m_icnt);
      chk("rnd_stat_stall", stat_stall_count, m_scnt);
`endif
      e_len = 0;
      if (exp_v) begin
        e_op  = mem[m_pc];
        e_len = ref_len(e_op);
        e_imm = 16'h0000;
        if (e_len >= 1) e_imm[7:0]  = mem[16'(m_pc + 16'd1)];
        if (e_len == 2) e_imm[15:8] = mem[16'(m_pc + 16'd2)];
        chk_instr("rnd", e_op, e_imm, e_len, m_pc);
        chk("rnd_addr", prog_mem_addr, 16'(m_pc + 16'(1 + e_len)));
      end
      ready_n = ($urandom_range(9) < 7);
      redir_n = ($urandom_range(39) == 0);
      case ($urandom_range(3))
        0:       raddr = 16'hFFFF;
        1:       raddr = 16'hFFFE;
        default: raddr = 16'($urandom);
      endcase
      instr_ready = ready_n; redirect_valid = redir_n; redirect_addr = raddr;
      accept = exp_v && ready_n;
`ifdef IFETCH_STATS_EN
      if (exp_v) begin
        if (ready_n) m_icnt++;
        else m_scnt++;
      end
`endif
      if (accept) begin
        m_pc   = 16'(m_pc + 16'(1 + e_len));
        m_wait = 1 + ref_len(mem[m_pc]);
      end
      if (redir_n) begin
        m_pc   = raddr;
        m_wait = 2 + ref_len(mem[raddr]);
      end else if (!accept && m_wait > 0) begin
        m_wait--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
